// File: rtl/armcpu_pkg.sv
// Shared definitions for the ARM core datapath: sequencer states, word size,
// PC register index and the block-transfer addressing modes.
package armcpu_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned PC_IDX    = 15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StWb   = 2'd2,
    StDone = 2'd3
  } seq_state_e;

  // Encoded directly as {p_bit, u_bit}.
  typedef enum logic [1:0] {
    ModeDa = 2'b00,
    ModeIa = 2'b01,
    ModeDb = 2'b10,
    ModeIb = 2'b11
  } xfer_mode_e;

  function automatic xfer_mode_e xfer_mode(input logic p_bit, input logic u_bit);
    return xfer_mode_e'({p_bit, u_bit});
  endfunction

endpackage

// File: rtl/reg_list_scan.sv
// Combinational scan of a register list: index of the lowest set bit, a
// non-empty flag and the population count.
module reg_list_scan #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(NUM_REGS + 1)
) (
  input  logic [NUM_REGS-1:0]   i_list,
  output logic [ADDR_WIDTH-1:0] o_idx,
  output logic                  o_valid,
  output logic [CNT_WIDTH-1:0]  o_count
);

  // Scan from the top so the lowest set bit is the last assignment to stick.
  always_comb begin
    o_idx   = '0;
    o_count = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (i_list[i]) begin
        o_idx = ADDR_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      o_count = o_count + CNT_WIDTH'(i_list[i]);
    end
  end

  assign o_valid = |i_list;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer. Walks the register list one register per
// memory beat, writes loaded words straight into the register file (or PC for
// r15) and performs base writeback at the end, holding busy while active.
// Optional build macro: LDM_STM_ABORT_EN adds mem_abort / aborted.
module ldm_stm_sequencer
  import armcpu_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = armcpu_pkg::WORD_SIZE,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_load,
  input  logic                  p_bit,
  input  logic                  u_bit,
  input  logic                  w_bit,
  input  logic [ADDR_WIDTH-1:0] base_reg,
  input  logic [WORD_SIZE-1:0]  base_val,
  input  logic [NUM_REGS-1:0]   reg_list,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [WORD_SIZE-1:0]  rf_read_data,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] write_rd,
  output logic [WORD_SIZE-1:0]  rd_in,
  output logic                  pc_we,
  output logic [WORD_SIZE-1:0]  pc_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  input  logic                  mem_ready,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  output logic                  busy,
`ifdef LDM_STM_ABORT_EN
  input  logic                  mem_abort,
  output logic                  aborted,
`endif
  output logic                  done
);

  localparam int unsigned CntWidth = $clog2(NUM_REGS + 1);

  seq_state_e r_state, w_state_next;

  logic [NUM_REGS-1:0]   r_list;
  logic [WORD_SIZE-1:0]  r_addr;
  logic [WORD_SIZE-1:0]  r_final_base;
  logic                  r_is_load;
  logic                  r_w;
  logic [ADDR_WIDTH-1:0] r_base_reg;
  logic                  r_wb_suppress;
  logic                  r_aborted;

  logic [NUM_REGS-1:0]   w_scan_list;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_valid;
  logic [CntWidth-1:0]   w_count;
  logic [WORD_SIZE-1:0]  w_four_n;
  logic [WORD_SIZE-1:0]  w_start_addr;
  logic [WORD_SIZE-1:0]  w_final_base;
  logic [NUM_REGS-1:0]   w_list_rem;
  logic                  w_launch;
  logic                  w_beat;
  logic                  w_abort;
  logic                  w_beat_ok;
  logic                  w_last;

  // The scanner sees the incoming list while idle (for the launch popcount)
  // and the shrinking latched list while transferring.
  assign w_scan_list = (r_state == StIdle) ? reg_list : r_list;

  reg_list_scan #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CntWidth)
  ) u_scan (
    .i_list  (w_scan_list),
    .o_idx   (w_idx),
    .o_valid (w_valid),
    .o_count (w_count)
  );

  assign w_launch   = (r_state == StIdle) && start;
  assign w_beat     = (r_state == StXfer) && mem_ready;
`ifdef LDM_STM_ABORT_EN
  assign w_abort    = w_beat && mem_abort;
`else
  assign w_abort    = 1'b0;
`endif
  assign w_beat_ok  = w_beat && !w_abort;
  assign w_list_rem = r_list & ~(NUM_REGS'(1) << w_idx);
  assign w_last     = (w_list_rem == '0);
  assign w_four_n   = WORD_SIZE'({w_count, 2'b00});
  assign w_final_base = u_bit ? (base_val + w_four_n) : (base_val - w_four_n);

  // Lowest address of the block; beats always ascend by 4 from here.
  always_comb begin
    case (xfer_mode(p_bit, u_bit))
      ModeIa:  w_start_addr = base_val;
      ModeIb:  w_start_addr = base_val + WORD_SIZE'(4);
      ModeDa:  w_start_addr = base_val - w_four_n + WORD_SIZE'(4);
      ModeDb:  w_start_addr = base_val - w_four_n;
      default: w_start_addr = base_val;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; an empty list with writeback still spends a WB cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (start) begin
          if (w_valid)    w_state_next = StXfer;
          else if (w_bit) w_state_next = StWb;
          else            w_state_next = StDone;
        end
      end
      StXfer: begin
        if (w_abort) begin
          w_state_next = StDone;
        end else if (w_beat && w_last) begin
          w_state_next = r_w ? StWb : StDone;
        end
      end
      StWb:    w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Operation context latched at launch; list and address advance per beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_list        <= '0;
      r_addr        <= '0;
      r_final_base  <= '0;
      r_is_load     <= 1'b0;
      r_w           <= 1'b0;
      r_base_reg    <= '0;
      r_wb_suppress <= 1'b0;
      r_aborted     <= 1'b0;
    end else if (w_launch) begin
      r_list        <= reg_list;
      r_addr        <= w_start_addr;
      r_final_base  <= w_final_base;
      r_is_load     <= is_load;
      r_w           <= w_bit;
      r_base_reg    <= base_reg;
      // Loaded base wins over writeback; an empty list writes nothing.
      r_wb_suppress <= (is_load && reg_list[base_reg]) || (reg_list == '0);
      r_aborted     <= 1'b0;
    end else if (w_abort) begin
      r_list    <= '0;
      r_aborted <= 1'b1;
    end else if (w_beat_ok) begin
      r_list <= w_list_rem;
      r_addr <= r_addr + WORD_SIZE'(4);
    end
  end

  // Outputs decoded from state; load data is forwarded in the completing cycle.
  always_comb begin
    rf_read_addr = '0;
    rd_we        = 1'b0;
    write_rd     = '0;
    rd_in        = '0;
    pc_we        = 1'b0;
    pc_in        = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    done         = 1'b0;
`ifdef LDM_STM_ABORT_EN
    aborted      = 1'b0;
`endif
    case (r_state)
      StXfer: begin
        mem_req      = 1'b1;
        mem_we       = !r_is_load;
        mem_addr     = r_addr;
        rf_read_addr = w_idx;
        mem_wdata    = rf_read_data;
        if (w_beat_ok && r_is_load) begin
          if (w_idx == ADDR_WIDTH'(PC_IDX)) begin
            pc_we = 1'b1;
            pc_in = mem_rdata;
          end else begin
            rd_we    = 1'b1;
            write_rd = w_idx;
            rd_in    = mem_rdata;
          end
        end
      end
      StWb: begin
        if (!r_wb_suppress) begin
          rd_we    = 1'b1;
          write_rd = r_base_reg;
          rd_in    = r_final_base;
        end
      end
      StDone: begin
        done = 1'b1;
`ifdef LDM_STM_ABORT_EN
        aborted = r_aborted;
`endif
      end
      default: ;
    endcase
  end

  assign busy = (r_state != StIdle);

endmodule
